motion_pi_ctrl: RTL and testbench

Parametrised line-follower motion controller, successor to `motion`. It sequences N IR emitter/receiver pairs through the shared A2D and forms a weighted steering error. A saturating PI loop turns that error into signed left/right motor drive words for the PWM/motor block. It adds a configurable pair count, configurable gains and decimation, a forward-speed ramp, and a controlled braking ramp when `go` drops.

---
 rtl/motion_pi_ctrl.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_motion_pi_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/motion_pi_ctrl.sv
// motion_pi_ctrl: line-follower steering controller.
// Scans NUM_PAIRS IR emitter/receiver pairs through a shared A2D. Each pair
// gives one right and one left reading, and the pairs are combined into a
// weighted steering error. A saturating PI loop turns that error into signed
// left/right drive words. When go drops, the forward speed ramps down to zero
// in steps before the block returns to idle.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   go                 run the loop while high, brake while low
//   A2D_res, cnv_cmplt conversion result (active-low sensor) and done level
//   strt_cnv, chnnl    one-cycle conversion start and A2D channel select
//   IR_en              one-hot emitter enable for the pair being measured
//   lft_reg, rht_reg   signed 12-bit motor drive words
//   dst_vld            one-cycle pulse alongside each drive-word update
module motion_pi_ctrl #(
    parameter int          NUM_PAIRS  = 3,
    parameter int          SETTLE_CYC = 4095,
    parameter int          PAIR_GAP   = 32,
    parameter logic [3:0]  P_COEF     = 4'd3,
    parameter logic [3:0]  I_COEF     = 4'd1,
    parameter int          INT_DEC    = 4,
    parameter logic [11:0] FWD_STEP   = 12'h040,
    parameter logic [11:0] MAX_FWD    = 12'h600,
    parameter int          RAMP_CYC   = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic [11:0]          A2D_res,
    input  logic                 cnv_cmplt,
    output logic                 strt_cnv,
    output logic [2:0]           chnnl,
    output logic [NUM_PAIRS-1:0] IR_en,
    output logic [11:0]          lft_reg,
    output logic [11:0]          rht_reg,
    output logic                 dst_vld
);

    typedef enum logic [3:0] {
        IDLE, SETTLE, CNV_R, GAP, CNV_L, NEXT_PAIR, CALC, OUTPUT, BRAKE
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] GAP_LAST    = 16'(PAIR_GAP - 1);
    localparam logic [15:0] RAMP_LAST   = 16'(RAMP_CYC - 1);
    localparam logic [3:0]  INT_LAST    = 4'(INT_DEC - 1);
    localparam logic [1:0]  K_LAST      = 2'(NUM_PAIRS - 1);

    // Clip a wide signed value into the 12-bit signed range.
    function automatic logic [11:0] sat12(input logic signed [17:0] v);
        if (v > 18'sd2047)       sat12 = 12'h7FF;
        else if (v < -18'sd2048) sat12 = 12'h800;
        else                     sat12 = v[11:0];
    endfunction

    // Clip the accumulator sum so a large error can never flip sign.
    function automatic logic [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767)       sat16 = 16'h7FFF;
        else if (v < -17'sd32768) sat16 = 16'h8000;
        else                      sat16 = v[15:0];
    endfunction

    function automatic logic [NUM_PAIRS-1:0] pair_onehot(input logic [1:0] idx);
        pair_onehot = NUM_PAIRS'(1'b1) << idx;
    endfunction

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [1:0]            k_q, k_d;
    logic signed [15:0]    err_acc_q, err_acc_d;
    logic [11:0]           rht_q, rht_d, lft_q, lft_d;
    logic signed [11:0]    intgrl_q, intgrl_d, pi_q, pi_d;
    logic [3:0]            int_cnt_q, int_cnt_d;
    logic [11:0]           fwd_q, fwd_d;
    logic [11:0]           lft_reg_q, lft_reg_d, rht_reg_q, rht_reg_d;
    logic                  strt_cnv_q, strt_cnv_d, dst_vld_q, dst_vld_d;
    logic [2:0]            chnnl_q, chnnl_d;
    logic [NUM_PAIRS-1:0]  ir_en_q, ir_en_d;
    logic                  abandon_s, restart_s;

    // Datapath: weighted pair error, PI terms, forward ramp and drive sums.
    logic signed [12:0] diff_s;
    logic signed [16:0] wdiff_s, acc_sum_s;
    logic signed [11:0] error_s, int_step_s, intgrl_nxt_s, pi_nxt_s;
    logic signed [17:0] intgrl_sum_s, p_term_s, i_term_s;
    logic [12:0]        fwd_inc_s;
    logic [11:0]        fwd_nxt_s, fwd_dec_s, lft_out_s, rht_out_s;

    assign diff_s       = $signed({1'b0, rht_q}) - $signed({1'b0, lft_q});
    assign wdiff_s      = $signed({{4{diff_s[12]}}, diff_s}) <<< k_q;
    assign acc_sum_s    = $signed({err_acc_q[15], err_acc_q}) + wdiff_s;
    assign error_s      = sat12($signed({{2{err_acc_q[15]}}, err_acc_q}));
    assign int_step_s   = error_s >>> 4;
    assign intgrl_sum_s = $signed({{6{intgrl_q[11]}}, intgrl_q})
                        + $signed({{6{int_step_s[11]}}, int_step_s});
    assign intgrl_nxt_s = (int_cnt_q == INT_LAST) ? sat12(intgrl_sum_s) : intgrl_q;
    assign p_term_s     = $signed({{6{error_s[11]}}, error_s}) * $signed({14'd0, P_COEF});
    assign i_term_s     = $signed({{6{intgrl_nxt_s[11]}}, intgrl_nxt_s})
                        * $signed({14'd0, I_COEF});
    assign pi_nxt_s     = sat12(p_term_s + i_term_s);
    assign fwd_inc_s    = {1'b0, fwd_q} + {1'b0, FWD_STEP};
    assign fwd_nxt_s    = (fwd_inc_s > {1'b0, MAX_FWD}) ? MAX_FWD : fwd_inc_s[11:0];
    assign fwd_dec_s    = (fwd_q > FWD_STEP) ? (fwd_q - FWD_STEP) : 12'h000;
    // fwd never exceeds 0x7FF, so it is always a non-negative signed value.
    assign lft_out_s    = sat12($signed({6'd0, fwd_q}) + $signed({{6{pi_q[11]}}, pi_q}));
    assign rht_out_s    = sat12($signed({6'd0, fwd_q}) - $signed({{6{pi_q[11]}}, pi_q}));

    // Next-state and register-update logic for the scan/PI/brake sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        err_acc_d = err_acc_q;
        rht_d     = rht_q;
        lft_d     = lft_q;
        intgrl_d  = intgrl_q;
        int_cnt_d = int_cnt_q;
        fwd_d     = fwd_q;
        pi_d      = pi_q;
        lft_reg_d = lft_reg_q;
        rht_reg_d = rht_reg_q;
        strt_cnv_d = 1'b0;
        chnnl_d   = chnnl_q;
        ir_en_d   = ir_en_q;
        dst_vld_d = 1'b0;
        abandon_s = 1'b0;
        restart_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) restart_s = 1'b1;
                else    state_d = IDLE;
            end
            SETTLE: begin
                if (!go) begin
                    abandon_s = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d    = CNV_R;
                    strt_cnv_d = 1'b1;
                    chnnl_d    = {k_q, 1'b0};
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CNV_R: begin
                // cnv_cmplt may still be high from the previous conversion
                // during the start pulse, so it is only trusted afterwards.
                if (strt_cnv_q) begin
                    state_d = CNV_R;
                end else if (cnv_cmplt) begin
                    rht_d = ~A2D_res;
                    cnt_d = 16'd0;
                    if (go) state_d = GAP;
                    else    abandon_s = 1'b1;
                end else begin
                    state_d = CNV_R;
                end
            end
            GAP: begin
                if (!go) begin
                    abandon_s = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d    = CNV_L;
                    strt_cnv_d = 1'b1;
                    chnnl_d    = {k_q, 1'b1};
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CNV_L: begin
                if (strt_cnv_q) begin
                    state_d = CNV_L;
                end else if (cnv_cmplt) begin
                    lft_d = ~A2D_res;
                    if (go) state_d = NEXT_PAIR;
                    else    abandon_s = 1'b1;
                end else begin
                    state_d = CNV_L;
                end
            end
            NEXT_PAIR: begin
                err_acc_d = sat16(acc_sum_s);
                if (!go) begin
                    abandon_s = 1'b1;
                end else if (k_q < K_LAST) begin
                    k_d     = k_q + 2'd1;
                    cnt_d   = 16'd0;
                    ir_en_d = pair_onehot(k_q + 2'd1);
                    state_d = SETTLE;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (!go) begin
                    abandon_s = 1'b1;
                end else begin
                    intgrl_d  = intgrl_nxt_s;
                    int_cnt_d = (int_cnt_q == INT_LAST) ? 4'd0 : (int_cnt_q + 4'd1);
                    fwd_d     = fwd_nxt_s;
                    pi_d      = pi_nxt_s;
                    state_d   = OUTPUT;
                end
            end
            OUTPUT: begin
                lft_reg_d = lft_out_s;
                rht_reg_d = rht_out_s;
                dst_vld_d = 1'b1;
                if (go) restart_s = 1'b1;
                else    abandon_s = 1'b1;
            end
            BRAKE: begin
                if (go) begin
                    restart_s = 1'b1;
                end else if (fwd_q == 12'h000) begin
                    state_d = IDLE;
                end else if (cnt_q == RAMP_LAST) begin
                    fwd_d     = fwd_dec_s;
                    lft_reg_d = fwd_dec_s;
                    rht_reg_d = fwd_dec_s;
                    dst_vld_d = 1'b1;
                    cnt_d     = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (restart_s) begin
            state_d   = SETTLE;
            k_d       = 2'd0;
            err_acc_d = 16'sd0;
            cnt_d     = 16'd0;
            ir_en_d   = pair_onehot(2'd0);
        end else if (abandon_s) begin
            // Entering BRAKE drops the integral history and the PI term.
            state_d   = BRAKE;
            intgrl_d  = 12'sd0;
            int_cnt_d = 4'd0;
            pi_d      = 12'sd0;
            cnt_d     = 16'd0;
            ir_en_d   = '0;
        end else begin
            restart_s = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            k_q        <= 2'd0;
            err_acc_q  <= 16'sd0;
            rht_q      <= 12'h000;
            lft_q      <= 12'h000;
            intgrl_q   <= 12'sd0;
            int_cnt_q  <= 4'd0;
            fwd_q      <= 12'h000;
            pi_q       <= 12'sd0;
            lft_reg_q  <= 12'h000;
            rht_reg_q  <= 12'h000;
            strt_cnv_q <= 1'b0;
            chnnl_q    <= 3'd0;
            ir_en_q    <= '0;
            dst_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            err_acc_q  <= err_acc_d;
            rht_q      <= rht_d;
            lft_q      <= lft_d;
            intgrl_q   <= intgrl_d;
            int_cnt_q  <= int_cnt_d;
            fwd_q      <= fwd_d;
            pi_q       <= pi_d;
            lft_reg_q  <= lft_reg_d;
            rht_reg_q  <= rht_reg_d;
            strt_cnv_q <= strt_cnv_d;
            chnnl_q    <= chnnl_d;
            ir_en_q    <= ir_en_d;
            dst_vld_q  <= dst_vld_d;
        end
    end

    assign strt_cnv = strt_cnv_q;
    assign chnnl    = chnnl_q;
    assign IR_en    = ir_en_q;
    assign lft_reg  = lft_reg_q;
    assign rht_reg  = rht_reg_q;
    assign dst_vld  = dst_vld_q;

endmodule

// File: tb/tb_motion_pi_ctrl.sv
// Directed bench for motion_pi_ctrl: a 3-pair instance with shortened
// timing and a 4-pair instance, each driven by a simple A2D model that
// returns a per-channel value a few cycles after every start pulse.
module tb_motion_pi_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, go, go4, hold;
    logic [11:0] A2D_res, A2D_res4;
    logic        cnv_cmplt, cnv_cmplt4;
    logic        strt_cnv, strt_cnv4, dst_vld, dst_vld4;
    logic [2:0]  chnnl, chnnl4;
    logic [2:0]  IR_en;
    logic [3:0]  IR_en4;
    logic [11:0] lft_reg, rht_reg, lft_reg4, rht_reg4;
    logic [11:0] tab [8];
    logic [11:0] tab4 [8];
    logic [11:0] expv;
    int          total = 0, bad = 0, strt_cnt = 0;
    int          ch4_q [$];

    always #5 clk = ~clk;

    motion_pi_ctrl #(.SETTLE_CYC(8), .PAIR_GAP(4), .RAMP_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .A2D_res(A2D_res), .cnv_cmplt(cnv_cmplt),
        .strt_cnv(strt_cnv), .chnnl(chnnl), .IR_en(IR_en), .lft_reg(lft_reg),
        .rht_reg(rht_reg), .dst_vld(dst_vld));

    motion_pi_ctrl #(.NUM_PAIRS(4), .SETTLE_CYC(8), .PAIR_GAP(4), .RAMP_CYC(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .go(go4), .A2D_res(A2D_res4), .cnv_cmplt(cnv_cmplt4),
        .strt_cnv(strt_cnv4), .chnnl(chnnl4), .IR_en(IR_en4), .lft_reg(lft_reg4),
        .rht_reg(rht_reg4), .dst_vld(dst_vld4));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance at least one cycle, then wait (bounded) for the next dst_vld.
    task automatic wait_vld(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!dst_vld && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!dst_vld) check_eq("vld_timeout", 32'd0, 32'd1);
    endtask

    // A2D model for the 3-pair instance; leaves the old done level high
    // through the start-pulse cycle, then clears it and answers later.
    initial begin
        int wait_c;
        logic [2:0] cur_ch;
        wait_c = 0; cur_ch = 3'd0;
        cnv_cmplt = 1'b0; A2D_res = 12'h000;
        forever begin
            @(posedge clk); #1;
            if (hold) begin
                wait_c = 0;
            end else if (strt_cnv) begin
                cur_ch = chnnl; wait_c = 4;
            end else if (wait_c > 0) begin
                wait_c--;
                if (wait_c == 3) cnv_cmplt = 1'b0;
                if (wait_c == 0) begin A2D_res = tab[cur_ch]; cnv_cmplt = 1'b1; end
            end
        end
    end

    // A2D model for the 4-pair instance.
    initial begin
        int wait_c;
        logic [2:0] cur_ch;
        wait_c = 0; cur_ch = 3'd0;
        cnv_cmplt4 = 1'b0; A2D_res4 = 12'h000;
        forever begin
            @(posedge clk); #1;
            if (strt_cnv4) begin
                cur_ch = chnnl4; wait_c = 4;
            end else if (wait_c > 0) begin
                wait_c--;
                if (wait_c == 3) cnv_cmplt4 = 1'b0;
                if (wait_c == 0) begin A2D_res4 = tab4[cur_ch]; cnv_cmplt4 = 1'b1; end
            end
        end
    end

    // Start-pulse monitor: emitter must be one-hot for the pair being converted.
    always @(negedge clk) begin
        if (strt_cnv) begin
            strt_cnt++;
            check_eq("ir_en_onehot", {29'd0, IR_en}, {29'd0, 3'b001 << chnnl[2:1]});
        end
        if (strt_cnv4) begin
            if (ch4_q.size() < 8) ch4_q.push_back(int'(chnnl4));
            check_eq("ir_en4_onehot", {28'd0, IR_en4}, {28'd0, 4'b0001 << chnnl4[2:1]});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0, nv, fw, pi, found;
        rst_n = 1'b0; go = 1'b0; go4 = 1'b0; hold = 1'b0;
        for (int i = 0; i < 8; i++) begin tab[i] = 12'h800; tab4[i] = 12'h800; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_strt", {31'd0, strt_cnv}, 32'd0);
        check_eq("rst_chnnl", {29'd0, chnnl}, 32'd0);
        check_eq("rst_ir_en", {29'd0, IR_en}, 32'd0);
        check_eq("rst_lft", {20'd0, lft_reg}, 32'd0);
        check_eq("rst_rht", {20'd0, rht_reg}, 32'd0);
        check_eq("rst_vld", {31'd0, dst_vld}, 32'd0);
        rst_n = 1'b1;

        // Balanced sensors: pure forward ramp up to the ceiling.
        go = 1'b1;
        for (int n = 1; n <= 26; n++) begin
            wait_vld(400);
            expv = (n >= 24) ? 12'h600 : 12'(n * 64);
            check_eq("ramp_lft", {20'd0, lft_reg}, {20'd0, expv});
            check_eq("ramp_rht", {20'd0, rht_reg}, {20'd0, expv});
            @(negedge clk);
            check_eq("vld_one_cycle", {31'd0, dst_vld}, 32'd0);
        end

        // Brake from 0x600 down to 0x300, then resume from there.
        go = 1'b0; s0 = strt_cnt;
        for (int i = 1; i <= 12; i++) begin
            wait_vld(100);
            expv = 12'h600 - 12'(i * 64);
            check_eq("brake_lft", {20'd0, lft_reg}, {20'd0, expv});
            check_eq("brake_rht", {20'd0, rht_reg}, {20'd0, expv});
        end
        check_eq("brake_no_strt", 32'(strt_cnt), 32'(s0));
        go = 1'b1;
        wait_vld(400);
        check_eq("resume_lft", {20'd0, lft_reg}, 32'h340);
        check_eq("resume_rht", {20'd0, rht_reg}, 32'h340);

        // Brake all the way to zero and fall back to idle.
        go = 1'b0; s0 = strt_cnt;
        for (int i = 1; i <= 13; i++) begin
            wait_vld(100);
            expv = 12'h340 - 12'(i * 64);
            check_eq("brake2_lft", {20'd0, lft_reg}, {20'd0, expv});
            check_eq("brake2_rht", {20'd0, rht_reg}, {20'd0, expv});
        end
        check_eq("brake2_no_strt", 32'(strt_cnt), 32'(s0));
        nv = 0;
        repeat (60) begin
            @(negedge clk);
            if (dst_vld || strt_cnv) nv++;
        end
        check_eq("idle_quiet", 32'(nv), 32'd0);

        // Pair 0 right = 0x100, left = 0: proportional plus slow integral.
        tab[0] = 12'hEFF; tab[1] = 12'hFFF;
        go = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            wait_vld(400);
            fw = 64 * n;
            pi = 768 + 16 * (n / 4);
            check_eq("pi_lft", {20'd0, lft_reg}, {20'd0, 12'(fw + pi)});
            check_eq("pi_rht", {20'd0, rht_reg}, {20'd0, 12'(fw - pi)});
        end

        // Reset while waiting on the left conversion of pair 0.
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (strt_cnv && chnnl == 3'd1) found = 1;
        end
        check_eq("cnv_l_reached", 32'(found), 32'd1);
        hold = 1'b1; cnv_cmplt = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_strt", {31'd0, strt_cnv}, 32'd0);
        check_eq("mid_rst_chnnl", {29'd0, chnnl}, 32'd0);
        check_eq("mid_rst_ir_en", {29'd0, IR_en}, 32'd0);
        check_eq("mid_rst_lft", {20'd0, lft_reg}, 32'd0);
        check_eq("mid_rst_rht", {20'd0, rht_reg}, 32'd0);
        check_eq("mid_rst_vld", {31'd0, dst_vld}, 32'd0);
        go = 1'b0; cnv_cmplt = 1'b1; A2D_res = 12'h000;
        rst_n = 1'b1;
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (dst_vld || strt_cnv || lft_reg != 12'h000) nv++;
        end
        check_eq("held_cmplt_idle", 32'(nv), 32'd0);

        // Pair 2 right = 0xFFF, left = 0: error and PI term both saturate.
        for (int i = 0; i < 8; i++) tab[i] = 12'h800;
        tab[4] = 12'h000; tab[5] = 12'hFFF;
        hold = 1'b0; go = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            wait_vld(400);
            check_eq("sat_lft", {20'd0, lft_reg}, 32'h7FF);
            check_eq("sat_rht", {20'd0, rht_reg}, {20'd0, 12'(64 * n - 2047)});
        end

        // Four-pair build: channel order and weight 8 on pair 3.
        tab4[6] = 12'hFFE; tab4[7] = 12'hFFF;
        go4 = 1'b1;
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            @(negedge clk);
            if (dst_vld4) found = 1;
        end
        check_eq("np4_vld_seen", 32'(found), 32'd1);
        check_eq("np4_lft", {20'd0, lft_reg4}, 32'h058);
        check_eq("np4_rht", {20'd0, rht_reg4}, 32'h028);
        check_eq("np4_ch_count", 32'(ch4_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < ch4_q.size()) check_eq("np4_ch_seq", 32'(ch4_q[i]), 32'(i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
